wb_arbiter: RTL and testbench

- Writeback stage directly upstream of the scalar/vector register file.
- Accepts results from SOURCES execution units over valid/ready handshakes and buffers each source in a small FIFO.
- Each cycle, round-robin arbitrates up to WRITE_PORTS results onto the register file's registered write ports (write_En/write_Addr/write_Data).
- Guarantees no two same-cycle writes to one address; writes to register 0 are discarded.

---
 rtl/wb_pkg.sv | 23 ++
 rtl/wb_fifo.sv | 56 +++++
 rtl/wb_arbiter.sv | 144 ++++++++++++++
 tb/tb_wb_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and widths for the writeback arbiter.
package wb_pkg;

  localparam int WB_DW    = 32;
  localparam int WB_AW    = 6;
  localparam int WB_SRC   = 4;
  localparam int WB_DEPTH = 2;
  localparam int WB_RR_W  = $clog2(WB_SRC);
  localparam int WB_PTR_W = $clog2(WB_DEPTH);

  typedef struct packed {
    logic [WB_AW-1:0] addr;
    logic [WB_DW-1:0] data;
  } wb_entry_t;

  function automatic int unsigned wb_wrap_inc(
    input int unsigned v,
    input int unsigned n
  );
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Per-source result buffer; ready depends only on occupancy.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  logic      pop,
  input  wb_entry_t in,
  output wb_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [PW:0]   cnt_q, cnt_d;
  wb_entry_t     mem_q [DEPTH];
  wb_entry_t     mem_d [DEPTH];
  logic          do_push, do_pop;

  assign full    = (cnt_q == (PW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign head    = mem_q[rd_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    mem_d = mem_q;
    if (do_push) mem_d[wr_q] = in;
    wr_d  = wr_q + PW'(do_push);
    rd_d  = rd_q + PW'(do_pop);
    cnt_d = cnt_q + (PW+1)'(do_push)
                  - (PW+1)'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: round-robin, distinct-address register file writes.
// Define WB_FWD_EN to add the write-port forwarding query ports.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH  = WB_DW,
  parameter int ADDR_WIDTH  = WB_AW,
  parameter int SOURCES     = WB_SRC,
  parameter int WRITE_PORTS = 2,
  parameter int DEPTH       = WB_DEPTH,
  parameter int READ_PORTS  = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic [SOURCES-1:0] src_valid,
  output logic [SOURCES-1:0] src_ready,
  input  logic [SOURCES-1:0][ADDR_WIDTH-1:0] src_addr,
  input  logic [SOURCES-1:0][DATA_WIDTH-1:0] src_data,
  output logic [WRITE_PORTS-1:0] write_En,
  output logic [WRITE_PORTS-1:0][ADDR_WIDTH-1:0] write_Addr,
  output logic [WRITE_PORTS-1:0][DATA_WIDTH-1:0] write_Data,
  output logic busy
`ifdef WB_FWD_EN
  ,
  input  logic [READ_PORTS-1:0][ADDR_WIDTH-1:0] fwd_Addr,
  output logic [READ_PORTS-1:0] fwd_hit,
  output logic [READ_PORTS-1:0][DATA_WIDTH-1:0] fwd_Data
`endif
);

  localparam int RW = (SOURCES > 1) ? $clog2(SOURCES) : 1;

  if (WRITE_PORTS < 1 || WRITE_PORTS > SOURCES ||
      SOURCES < 2 || READ_PORTS < 1) begin : g_bad
    $error("wb_arbiter: bad parameters");
  end

  logic [SOURCES-1:0] full, empty, pop;
  wb_entry_t          head [SOURCES];

  logic [RW-1:0] rr_q, rr_d;
  logic [WRITE_PORTS-1:0] we_q, we_d;
  logic [WRITE_PORTS-1:0][ADDR_WIDTH-1:0] wa_q, wa_d;
  logic [WRITE_PORTS-1:0][DATA_WIDTH-1:0] wd_q, wd_d;

  logic [WRITE_PORTS-1:0] slot_v;
  logic [WRITE_PORTS-1:0][ADDR_WIDTH-1:0] slot_a;
  logic [WRITE_PORTS-1:0][DATA_WIDTH-1:0] slot_d;

  assign src_ready = ~full & {SOURCES{~rst}};

  for (genvar g = 0; g < SOURCES; g++) begin : g_src
    wb_entry_t in_e;
    assign in_e.addr = src_addr[g];
    assign in_e.data = src_data[g];
    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (src_valid[g] & src_ready[g]),
      .pop   (pop[g]),
      .in    (in_e),
      .head  (head[g]),
      .full  (full[g]),
      .empty (empty[g])
    );
  end

  // Scan from rr_q; skip heads whose address is already granted.
  always_comb begin
    int            n;
    logic [RW-1:0] idx;
    logic [RW-1:0] last;
    logic          hit;
    pop    = '0;
    slot_v = '0;
    slot_a = '0;
    slot_d = '0;
    n      = 0;
    last   = rr_q;
    for (int k = 0; k < SOURCES; k++) begin
      idx = RW'((int'(rr_q) + k) % SOURCES);
      hit = 1'b0;
      for (int s = 0; s < WRITE_PORTS; s++)
        if (slot_v[s] && slot_a[s] == head[idx].addr)
          hit = 1'b1;
      if (!empty[idx] && n < WRITE_PORTS && !hit) begin
        for (int s = 0; s < WRITE_PORTS; s++)
          if (s == n) begin
            slot_v[s] = 1'b1;
            slot_a[s] = head[idx].addr;
            slot_d[s] = head[idx].data;
          end
        pop[idx] = 1'b1;
        last     = idx;
        n        = n + 1;
      end
    end
    rr_d = (n > 0)
         ? RW'(wb_wrap_inc(int'(last), SOURCES))
         : rr_q;
  end

  always_comb begin
    for (int s = 0; s < WRITE_PORTS; s++) begin
      we_d[s] = slot_v[s] & (slot_a[s] != '0);
      wa_d[s] = slot_v[s] ? slot_a[s] : wa_q[s];
      wd_d[s] = slot_v[s] ? slot_d[s] : wd_q[s];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q <= '0;
      we_q <= '0;
      wa_q <= '0;
      wd_q <= '0;
    end else begin
      rr_q <= rr_d;
      we_q <= we_d;
      wa_q <= wa_d;
      wd_q <= wd_d;
    end
  end

  assign write_En   = we_q;
  assign write_Addr = wa_q;
  assign write_Data = wd_q;
  assign busy       = (|(~empty)) | (|we_q);

`ifdef WB_FWD_EN
  always_comb begin
    fwd_hit  = '0;
    fwd_Data = '0;
    for (int i = 0; i < READ_PORTS; i++)
      for (int j = 0; j < WRITE_PORTS; j++)
        if (we_q[j] && wa_q[j] == fwd_Addr[i] &&
            fwd_Addr[i] != '0) begin
          fwd_hit[i]  = 1'b1;
          fwd_Data[i] = wd_q[j];
        end
  end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: expected writes queued at issue time.
module tb_wb_arbiter;

  localparam int DW = 32;
  localparam int AW = 6;
  localparam int NS = 4;
  localparam int WP = 2;
  localparam int RP = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NS-1:0] src_valid = '0;
  logic [NS-1:0] src_ready;
  logic [NS-1:0][AW-1:0] src_addr = '0;
  logic [NS-1:0][DW-1:0] src_data = '0;
  logic [WP-1:0] write_En;
  logic [WP-1:0][AW-1:0] write_Addr;
  logic [WP-1:0][DW-1:0] write_Data;
  logic busy;
`ifdef WB_FWD_EN
  logic [RP-1:0][AW-1:0] fwd_Addr = '0;
  logic [RP-1:0] fwd_hit;
  logic [RP-1:0][DW-1:0] fwd_Data;
`endif

  wb_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SOURCES(NS),
    .WRITE_PORTS(WP), .DEPTH(2), .READ_PORTS(RP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .src_valid  (src_valid),
    .src_ready  (src_ready),
    .src_addr   (src_addr),
    .src_data   (src_data),
    .write_En   (write_En),
    .write_Addr (write_Addr),
    .write_Data (write_Data),
    .busy       (busy)
`ifdef WB_FWD_EN
    ,
    .fwd_Addr   (fwd_Addr),
    .fwd_hit    (fwd_hit),
    .fwd_Data   (fwd_Data)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int            slot;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_vec = 0;
  int   n_err = 0;

  function automatic logic [DW-1:0] dat(input int a);
    return 32'hC0DE_0000 + DW'(a);
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  task automatic expw(input int s, input int a,
                      input logic [DW-1:0] d);
    exp_t x;
    x.slot = s;
    x.addr = AW'(a);
    x.data = d;
    exp_q.push_back(x);
  endtask

  task automatic drv(input int s, input int a,
                     input logic [DW-1:0] d);
    src_valid[s] = 1'b1;
    src_addr[s]  = AW'(a);
    src_data[s]  = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int max);
    for (int i = 0; i < max && exp_q.size() != 0; i++)
      step();
    chk("drain", 64'(exp_q.size()), 64'd0);
    step();
    step();
    chk("idle_busy", 64'(busy), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    src_valid = '0;
    step();
    chk("rst_ready", 64'(src_ready), 64'd0);
    chk("rst_we", 64'(write_En), 64'd0);
    chk("rst_addr", 64'(write_Addr), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    step();
    rst = 1'b0;
    #1;
    chk("rel_ready", 64'(src_ready), 64'hF);
    step();
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int p = 0; p < WP; p++) begin
        if (write_En[p]) begin
          n_vec++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexp_write: slot %0d a=%0h d=%0h want none",
                     p, write_Addr[p], write_Data[p]);
          end else begin
            e = exp_q.pop_front();
            if (e.slot != p || e.addr !== write_Addr[p] ||
                e.data !== write_Data[p]) begin
              n_err++;
              $display("FAIL write: slot %0d a=%0h d=%0h want slot %0d a=%0h d=%0h",
                       p, write_Addr[p], write_Data[p],
                       e.slot, e.addr, e.data);
            end
          end
        end
      end
    end
  end

  initial begin
    do_reset();

    // single result
    drv(0, 5, 32'hDEAD);
    expw(0, 5, 32'hDEAD);
    step();
    src_valid = '0;
    step();
    chk("t1_busy_hi", 64'(busy), 64'd1);
`ifdef WB_FWD_EN
    fwd_Addr[0] = 6'd5;
    fwd_Addr[1] = 6'd6;
    #1;
    chk("t1_fwd_hit", 64'(fwd_hit), 64'd1);
    chk("t1_fwd_data", 64'(fwd_Data[0]), 64'hDEAD);
    fwd_Addr = '0;
`endif
    step();
    chk("t1_busy_lo", 64'(busy), 64'd0);

    // four sources together from rr_ptr 0
    do_reset();
    for (int s = 0; s < NS; s++) drv(s, s + 1, dat(s + 1));
    expw(0, 1, dat(1));
    expw(1, 2, dat(2));
    expw(0, 3, dat(3));
    expw(1, 4, dat(4));
    step();
    src_valid = '0;
    drain(20);

    // same-address conflict; rr_ptr back at 0
    drv(0, 7, 32'h11);
    drv(1, 7, 32'h22);
    expw(0, 7, 32'h11);
    expw(0, 7, 32'h22);
    step();
    src_valid = '0;
    drain(20);

    // address 0 is consumed silently
    drv(2, 0, 32'h55);
    step();
    src_valid = '0;
    step();
    chk("t4_we", 64'(write_En), 64'd0);
    chk("t4_addr0", 64'(write_Addr[0]), 64'd0);
    chk("t4_data0", 64'(write_Data[0]), 64'h55);
    chk("t4_busy", 64'(busy), 64'd0);
    chk("t4_ready", 64'(src_ready), 64'hF);

    // backpressure on src1; first move rr_ptr to 2
    do_reset();
    drv(0, 50, dat(50));
    drv(1, 51, dat(51));
    expw(0, 50, dat(50));
    expw(1, 51, dat(51));
    step();
    src_valid = '0;
    drain(20);
    expw(0, 20, dat(20));
    expw(1, 30, dat(30));
    expw(0, 40, dat(40));
    expw(1, 21, dat(21));
    expw(0, 31, dat(31));
    expw(1, 41, dat(41));
    expw(0, 42, dat(42));
    drv(1, 40, dat(40));
    drv(2, 20, dat(20));
    drv(3, 30, dat(30));
    step();
    chk("t5_rdy_e1", 64'(src_ready[1]), 64'd1);
    drv(1, 41, dat(41));
    drv(2, 21, dat(21));
    drv(3, 31, dat(31));
    step();
    chk("t5_rdy_full", 64'(src_ready[1]), 64'd0);
    src_valid[2] = 1'b0;
    src_valid[3] = 1'b0;
    drv(1, 42, dat(42));
    step();
    chk("t5_rdy_pop", 64'(src_ready[1]), 64'd1);
    step();
    src_valid = '0;
    chk("t5_busy", 64'(busy), 64'd1);
    drain(20);

    // reset with three entries buffered
    drv(0, 9, dat(9));
    drv(1, 9, dat(10));
    drv(2, 9, dat(11));
    step();
    src_valid = '0;
    rst = 1'b1;
    #1;
    chk("t6_we", 64'(write_En), 64'd0);
    chk("t6_ready", 64'(src_ready), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
`ifdef WB_FWD_EN
    fwd_Addr[0] = 6'd9;
    #1;
    chk("t6_fwd", 64'(fwd_hit), 64'd0);
`endif
    step();
    step();
    rst = 1'b0;
    #1;
    chk("t6_rel_ready", 64'(src_ready), 64'hF);
    step();
    chk("t6_rel_we", 64'(write_En), 64'd0);
`ifdef WB_FWD_EN
    chk("t6_rel_fwd", 64'(fwd_hit), 64'd0);
`endif
    for (int i = 0; i < 4; i++) step();
    chk("t6_busy_end", 64'(busy), 64'd0);
    chk("final_q", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: sim still running, want finished");
    $fatal(1);
  end

endmodule
